// File: rtl/dm_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: pipeline MEM-stage request,
// DMA requester, and the single-port data-memory connection.
interface dm_port_arbiter_if #(
    parameter int DATA_W = 32
);
    // Pipeline MEM stage (from EX_MEM)
    logic              cpu_MemRead;
    logic              cpu_MemWrite;
    logic [DATA_W-1:0] cpu_Addr;
    logic [DATA_W-1:0] cpu_WriteData;
    logic [DATA_W-1:0] cpu_ReadData;
    logic              cpu_Stall;

    // DMA handshake: a transfer happens on every rising edge where
    // dma_valid & dma_ready are both high. Once dma_valid rises, the requester
    // keeps it high with dma_write/dma_addr/dma_wdata stable until dma_ready;
    // dma_ready may depend combinationally on dma_valid. Read data comes back
    // one cycle later as a single-cycle dma_rvalid pulse with dma_rdata.
    logic              dma_valid;
    logic              dma_write;
    logic [DATA_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ready;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic [1:0]        owner;

    // Data memory
    logic [DATA_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] MemReadData;

    modport slave (
        input  cpu_MemRead, cpu_MemWrite, cpu_Addr, cpu_WriteData,
        output cpu_ReadData, cpu_Stall,
        input  dma_valid, dma_write, dma_addr, dma_wdata,
        output dma_ready, dma_rdata, dma_rvalid,
        output owner,
        output MemAddr, MemWriteData, MemRead, MemWrite,
        input  MemReadData
    );

    modport master (
        output cpu_MemRead, cpu_MemWrite, cpu_Addr, cpu_WriteData,
        input  cpu_ReadData, cpu_Stall,
        output dma_valid, dma_write, dma_addr, dma_wdata,
        input  dma_ready, dma_rdata, dma_rvalid,
        input  owner,
        input  MemAddr, MemWriteData, MemRead, MemWrite,
        output MemReadData
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and a DMA
// requester. The pipeline has priority; a starvation counter bounds DMA waiting.
module dm_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dm_port_arbiter_if.slave    bus,
    output logic [3:0]          dbg_wait_cnt_o
);
    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    owner_e            owner_q, owner_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic cpu_req;
    logic grant_cpu;
    logic grant_dma;

    // Grants are qualified by rst_n so that nothing reaches DM while in reset.
    always_comb begin
        cpu_req   = bus.cpu_MemRead | bus.cpu_MemWrite;
        grant_dma = rst_n & bus.dma_valid & (~cpu_req | (wait_cnt_q == STARVE_MAX_C));
        grant_cpu = rst_n & cpu_req & ~grant_dma;
    end

    always_comb begin
        bus.MemAddr      = '0;
        bus.MemWriteData = '0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.cpu_ReadData = '0;
        bus.cpu_Stall    = 1'b0;
        bus.dma_ready    = 1'b0;
        if (grant_dma) begin
            bus.MemAddr      = bus.dma_addr;
            bus.MemWriteData = bus.dma_wdata;
            bus.MemWrite     = bus.dma_write;
            bus.MemRead      = ~bus.dma_write;
            bus.dma_ready    = 1'b1;
            bus.cpu_Stall    = cpu_req;
        end else if (grant_cpu) begin
            bus.MemAddr      = bus.cpu_Addr;
            bus.MemWriteData = bus.cpu_WriteData;
            bus.MemWrite     = bus.cpu_MemWrite;
            bus.MemRead      = bus.cpu_MemRead;
            bus.cpu_ReadData = bus.MemReadData;
        end
    end

    always_comb begin
        owner_d      = OWN_IDLE;
        wait_cnt_d   = wait_cnt_q;
        dma_rvalid_d = 1'b0;
        dma_rdata_d  = dma_rdata_q;

        if (grant_dma) begin
            owner_d = OWN_DMA;
        end else if (grant_cpu) begin
            owner_d = OWN_CPU;
        end

        // Counts consecutive cycles a waiting DMA request lost to the CPU.
        if (!bus.dma_valid || grant_dma) begin
            wait_cnt_d = '0;
        end else if (grant_cpu && (wait_cnt_q < STARVE_MAX_C)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        if (grant_dma && !bus.dma_write) begin
            dma_rvalid_d = 1'b1;
            dma_rdata_d  = bus.MemReadData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_IDLE;
            wait_cnt_q   <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.owner      = owner_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.dma_rdata  = dma_rdata_q;
    assign dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single-port data memory between the pipeline MEM stage and an external DMA/loader requester. The pipeline has priority, but a starvation counter bounds how long the DMA can wait. When the DMA wins a cycle in which the pipeline also wants memory, the arbiter raises a stall to the hazard logic. The block sits between the EX_MEM pipeline register outputs, the DMA port and DM, replacing the direct EX_MEM-to-DM connection.

## Interface
Parameters:
- DATA_W, 32, width of data and address buses
- STARVE_MAX, 4, consecutive lost arbitrations after which a waiting DMA request wins; legal range 1..15

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_MemRead  in  1  MEM-stage read request (from EX_MEM)
- cpu_MemWrite  in  1  MEM-stage write request (from EX_MEM)
- cpu_Addr  in  DATA_W  MEM-stage address (EX_MEM ALU result)
- cpu_WriteData  in  DATA_W  MEM-stage store data
- cpu_ReadData  out  DATA_W  load data to MEM_WB; DM data when CPU granted, else 0
- cpu_Stall  out  1  CPU request denied this cycle; freeze PC/IF_ID/ID_EX/EX_MEM, bubble into MEM_WB
- dma_valid  in  1  DMA request valid
- dma_write  in  1  1 = write, 0 = read
- dma_addr  in  DATA_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_ready  out  1  DMA granted; transfer occurs when dma_valid & dma_ready
- dma_rdata  out  DATA_W  registered read data
- dma_rvalid  out  1  one-cycle pulse; dma_rdata valid
- owner  out  2  registered previous-cycle owner: 00 IDLE, 01 CPU, 10 DMA
- MemAddr, MemWriteData  out  DATA_W  to DM
- MemRead, MemWrite  out  1  to DM
- MemReadData  in  DATA_W  from DM (combinational read)

## Operation
- cpu_req = cpu_MemRead | cpu_MemWrite.
- Grant decision is combinational from the current-cycle inputs and wait_cnt:
  - if dma_valid and (not cpu_req, or wait_cnt == STARVE_MAX): grant DMA.
  - else if cpu_req: grant CPU.
  - else: no grant.
- CPU grant:
  - DM ports are driven from the cpu_* inputs.
  - cpu_ReadData = MemReadData.
  - cpu_Stall = 0.
  - dma_ready = 0.
- DMA grant:
  - MemAddr = dma_addr and MemWriteData = dma_wdata.
  - MemWrite = dma_write and MemRead = ~dma_write.
  - dma_ready = 1.
  - cpu_Stall = cpu_req.
- No grant: all DM enables 0, MemAddr/MemWriteData = 0, cpu_Stall = 0.
- A stalled CPU request is held by the frozen EX_MEM register and re-arbitrates the next cycle. The arbiter never latches CPU requests.
- wait_cnt (4-bit), updated each edge:
  - cleared on a DMA grant or when dma_valid = 0;
  - incremented when dma_valid = 1 and the CPU is granted;
  - saturates at STARVE_MAX.
- The owner FSM has states IDLE, CPU and DMA. Next state is the grant of the current cycle; any state may go to any state.
- DMA read response:
  - on a DMA read transfer, MemReadData is captured into dma_rdata and dma_rvalid = 1 the next cycle;
  - otherwise dma_rvalid = 0 and dma_rdata holds its value.
- The CPU never sees more than STARVE_MAX consecutive grants while the DMA is waiting. The DMA never waits more than STARVE_MAX+1 cycles.

## Timing
- Reset values:
  - owner = IDLE (00), wait_cnt = 0, dma_rvalid = 0, dma_rdata = 0.
  - While rst_n = 0, these combinational outputs are forced to 0: MemRead, MemWrite, dma_ready, cpu_Stall.
- Reset asserts asynchronously and releases synchronously to the design. Reset mid-transfer drops the access; no dma_rvalid follows.
- Write latency: 0 cycles. DM commits on the edge that ends the grant cycle.
- CPU read: same-cycle cpu_ReadData.
- DMA read: dma_rvalid and dma_rdata one cycle after the transfer.
- Back-to-back DMA transfers are allowed every cycle when the CPU is idle.
- cpu_Stall, dma_ready and the DM outputs are combinational. There is no path from cpu_Stall back to cpu_* inside this block.
- Simultaneous events:
  - CPU and DMA both request with wait_cnt < STARVE_MAX: CPU wins and wait_cnt increments.
  - Both request at the threshold: DMA wins, cpu_Stall = 1, wait_cnt clears.
- dma_valid must stay high with stable fields until dma_ready. Dropping it early clears wait_cnt.

## Test plan
- Reset: hold rst_n = 0 with all requests high -> MemRead/MemWrite/dma_ready/cpu_Stall = 0, owner = 00. Release rst_n -> CPU granted in the first cycle.
- CPU only: cpu_MemWrite to 0x10 with data 0xDEADBEEF, then cpu_MemRead from 0x10 -> cpu_ReadData = 0xDEADBEEF in the read cycle, cpu_Stall = 0 throughout.
- DMA only: DMA write 0x20 <- 0x12345678, then DMA read 0x20 -> dma_ready = 1 in both cycles, and dma_rvalid pulses one cycle after the read with dma_rdata = 0x12345678.
- Starvation bound: cpu_MemRead held high and dma_valid held high with STARVE_MAX = 4 -> CPU granted 4 cycles, DMA granted in cycle 5 with cpu_Stall = 1, then CPU resumes. The pattern repeats with period 5.
- Early withdrawal: dma_valid high for 2 cycles under CPU load, low 1 cycle, high again -> wait_cnt restarts at 0, and the DMA is granted 5 cycles after re-assertion.
- Reset mid-operation: assert rst_n = 0 in the cycle of a DMA read transfer -> no dma_rvalid after reset, dma_rdata = 0, wait_cnt = 0.
